// File: rtl/pipe_reg_chain_if.sv
// rtl/pipe_reg_chain_if.sv - upstream and downstream valid/ready ports of pipe_reg_chain
interface pipe_reg_chain_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - DEPTH-stage valid/ready register pipeline with bubble collapse
// Optional synchronous flush port enabled by PIPE_REG_FLUSH_EN.
module pipe_reg_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PIPE_REG_FLUSH_EN
  input  logic             flush,
`endif
  pipe_reg_chain_if.slave  bus,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] en;
  logic [WIDTH-1:0] d [DEPTH];
  logic             fl;
  logic             take_out;

`ifdef PIPE_REG_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif

  assign take_out = v[DEPTH-1] & bus.out_ready & ~fl;

  // A stage may load when some stage at or beyond it is empty, or the full tail drains this cycle.
  always_comb begin : enable_calc
    logic full_tail;
    full_tail = 1'b1;
    en        = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      full_tail = full_tail & v[i];
      en[i]     = ~full_tail | take_out;
    end
  end

  assign bus.in_ready  = en[0] & ~fl;
  assign bus.out_valid = v[DEPTH-1] & ~fl;
  assign bus.out_data  = d[DEPTH-1];
  assign occupancy     = CNT_W'($countones(v));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else if (fl) begin
      v <= '0;
    end else begin
      if (en[0]) begin
        v[0] <= bus.in_valid;
        if (bus.in_valid) begin
          d[0] <= bus.in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (en[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            d[i] <= d[i-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - self-checking bench for pipe_reg_chain (DEPTH=4 and DEPTH=1)
module tb_pipe_reg_chain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_reg_chain_if #(.WIDTH(8)) b4 ();
  pipe_reg_chain_if #(.WIDTH(8)) b1 ();
  logic [2:0] occ4;
  logic [0:0] occ1;
`ifdef PIPE_REG_FLUSH_EN
  logic flush4 = 1'b0;
  logic flush1 = 1'b0;
`endif

  pipe_reg_chain #(.WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst),
`ifdef PIPE_REG_FLUSH_EN
    .flush(flush4),
`endif
    .bus(b4), .occupancy(occ4)
  );

  pipe_reg_chain #(.WIDTH(8), .DEPTH(1)) u1 (
    .clk(clk), .rst(rst),
`ifdef PIPE_REG_FLUSH_EN
    .flush(flush1),
`endif
    .bus(b1), .occupancy(occ1)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: words in flight, oldest first, with their stage position.
  logic [7:0] mq_d [2][$];
  int         mq_p [2][$];

  function automatic int dep(int u);
    return (u == 0) ? 4 : 1;
  endfunction

  function automatic bit m_out_valid(int u);
    return (mq_d[u].size() > 0) && (mq_p[u][0] == dep(u) - 1);
  endfunction

  function automatic bit m_in_ready(int u, bit ordy);
    return (mq_d[u].size() < dep(u)) || (m_out_valid(u) && ordy);
  endfunction

  task automatic m_edge(int u, bit acc, bit emit, logic [7:0] data);
    int lim;
    int np;
    if (emit) begin
      void'(mq_d[u].pop_front());
      void'(mq_p[u].pop_front());
    end
    if (acc) begin
      mq_d[u].push_back(data);
      mq_p[u].push_back(-1);
    end
    lim = dep(u);
    for (int k = 0; k < mq_p[u].size(); k++) begin
      np = mq_p[u][k] + 1;
      if (np > lim - 1) np = lim - 1;
      mq_p[u][k] = np;
      lim = np;
    end
  endtask

  task automatic idle_inputs();
    b4.in_valid = 1'b0; b4.in_data = 8'h00; b4.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = 8'h00; b1.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      mq_d[u].delete();
      mq_p[u].delete();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    #1;
    tests++;
    if (b4.out_valid !== 1'b0 || occ4 !== 3'd0 || b4.in_ready !== 1'b1 || b4.out_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_initial: out_valid=%b occ=%0d in_ready=%b out_data=%h, want 0 0 1 00",
               b4.out_valid, occ4, b4.in_ready, b4.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b4.in_valid = 1'b1;
      b4.in_data  = 8'hC0 + 8'(i);
    end
    @(negedge clk);
    b4.in_valid = 1'b0;
    @(posedge clk);
    #2;
    tests++;
    if (occ4 !== 3'd3) begin
      fails++;
      $display("FAIL reset_preload: occ=%0d want 3", occ4);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (b4.out_valid !== 1'b0 || occ4 !== 3'd0 || b4.in_ready !== 1'b1 || b4.out_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_async: out_valid=%b occ=%0d in_ready=%b out_data=%h, want 0 0 1 00",
               b4.out_valid, occ4, b4.in_ready, b4.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      b4.in_valid  = (i < 16);
      b4.in_data   = 8'(i + 1);
      b4.out_ready = 1'b1;
      #1;
      tests++;
      if (b4.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_in_ready cyc %0d: got %b want 1", i, b4.in_ready);
      end
      tests++;
      if (b4.out_valid !== ((i >= 4) && (i < 20))) begin
        fails++;
        $display("FAIL stream_out_valid cyc %0d: got %b want %b", i, b4.out_valid, (i >= 4) && (i < 20));
      end
      if (i >= 4 && i < 20) begin
        tests++;
        if (b4.out_data !== 8'(i - 3)) begin
          fails++;
          $display("FAIL stream_data cyc %0d: got %h want %h", i, b4.out_data, 8'(i - 3));
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b4.in_valid  = 1'b1;
      b4.in_data   = 8'hA0 + 8'(i);
      b4.out_ready = 1'b0;
      #1;
      if (b4.in_ready === 1'b1) acc++;
    end
    @(negedge clk);
    b4.in_valid = 1'b0;
    #1;
    tests++;
    if (acc != 4 || b4.in_ready !== 1'b0 || occ4 !== 3'd4) begin
      fails++;
      $display("FAIL bp_full: accepted=%0d in_ready=%b occ=%0d, want 4 0 4", acc, b4.in_ready, occ4);
    end
    @(negedge clk);
    b4.in_valid  = 1'b1;
    b4.in_data   = 8'hA6;
    b4.out_ready = 1'b1;
    #1;
    tests++;
    if (b4.in_ready !== 1'b1 || occ4 !== 3'd4 || b4.out_data !== 8'hA0) begin
      fails++;
      $display("FAIL bp_passthru: in_ready=%b occ=%0d out_data=%h, want 1 4 a0", b4.in_ready, occ4, b4.out_data);
    end
    @(negedge clk);
    b4.in_valid  = 1'b0;
    b4.out_ready = 1'b0;
    #1;
    tests++;
    if (occ4 !== 3'd4 || b4.out_data !== 8'hA1) begin
      fails++;
      $display("FAIL bp_after: occ=%0d out_data=%h, want 4 a1", occ4, b4.out_data);
    end
  endtask

  task automatic test_bubble();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      b4.out_ready = 1'b0;
      b4.in_valid  = (i == 0) || (i == 3);
      b4.in_data   = (i == 0) ? 8'h11 : 8'h22;
    end
    @(negedge clk);
    b4.in_valid = 1'b0;
    #1;
    tests++;
    if (occ4 !== 3'd2 || b4.in_ready !== 1'b1 || b4.out_valid !== 1'b1 || b4.out_data !== 8'h11) begin
      fails++;
      $display("FAIL bubble_settle: occ=%0d in_ready=%b out_valid=%b out_data=%h, want 2 1 1 11",
               occ4, b4.in_ready, b4.out_valid, b4.out_data);
    end
    b4.out_ready = 1'b1;
    @(negedge clk);
    b4.out_ready = 1'b0;
    #1;
    tests++;
    if (occ4 !== 3'd1 || b4.out_valid !== 1'b1 || b4.out_data !== 8'h22) begin
      fails++;
      $display("FAIL bubble_adjacent: occ=%0d out_valid=%b out_data=%h, want 1 1 22", occ4, b4.out_valid, b4.out_data);
    end
  endtask

`ifdef PIPE_REG_FLUSH_EN
  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b4.in_valid = 1'b1;
      b4.in_data  = 8'h31 + 8'(i);
    end
    @(negedge clk);
    b4.in_valid = 1'b0;
    #1;
    tests++;
    if (occ4 !== 3'd3) begin
      fails++;
      $display("FAIL flush_pre: occ=%0d want 3", occ4);
    end
    @(negedge clk);
    flush4       = 1'b1;
    b4.in_valid  = 1'b1;
    b4.in_data   = 8'h77;
    b4.out_ready = 1'b1;
    #1;
    tests++;
    if (b4.in_ready !== 1'b0 || b4.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_block: in_ready=%b out_valid=%b, want 0 0", b4.in_ready, b4.out_valid);
    end
    @(negedge clk);
    flush4      = 1'b0;
    b4.in_valid = 1'b0;
    #1;
    tests++;
    if (occ4 !== 3'd0 || b4.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_clear: occ=%0d out_valid=%b, want 0 0", occ4, b4.out_valid);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b4.in_valid = (i == 0);
      b4.in_data  = 8'h5A;
      #1;
      tests++;
      if (b4.out_valid !== (i == 4) || (i == 4 && b4.out_data !== 8'h5A)) begin
        fails++;
        $display("FAIL flush_next cyc %0d: out_valid=%b out_data=%h, want %b 5a", i, b4.out_valid, b4.out_data, i == 4);
      end
    end
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    bit         iv   [2];
    bit         ordy [2];
    logic [7:0] dat  [2];
    bit         o_ir [2];
    bit         o_ov [2];
    logic [7:0] o_od [2];
    int         o_oc [2];
    bit         acc, emit;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        iv[u]   = 1'($urandom_range(0, 1));
        ordy[u] = 1'($urandom_range(0, 1));
        dat[u]  = 8'($urandom);
      end
      b4.in_valid = iv[0]; b4.out_ready = ordy[0]; b4.in_data = dat[0];
      b1.in_valid = iv[1]; b1.out_ready = ordy[1]; b1.in_data = dat[1];
      #1;
      o_ir[0] = b4.in_ready; o_ov[0] = b4.out_valid; o_od[0] = b4.out_data; o_oc[0] = int'(occ4);
      o_ir[1] = b1.in_ready; o_ov[1] = b1.out_valid; o_od[1] = b1.out_data; o_oc[1] = int'(occ1);
      for (int u = 0; u < 2; u++) begin
        tests++;
        if (o_ir[u] !== m_in_ready(u, ordy[u]) || o_ov[u] !== m_out_valid(u) || o_oc[u] != mq_d[u].size()) begin
          fails++;
          $display("FAIL rand_ctrl depth%0d cyc %0d: in_ready=%b out_valid=%b occ=%0d, want %b %b %0d",
                   dep(u), c, o_ir[u], o_ov[u], o_oc[u], m_in_ready(u, ordy[u]), m_out_valid(u), mq_d[u].size());
        end
        if (m_out_valid(u)) begin
          tests++;
          if (o_od[u] !== mq_d[u][0]) begin
            fails++;
            $display("FAIL rand_data depth%0d cyc %0d: out_data=%h want %h", dep(u), c, o_od[u], mq_d[u][0]);
          end
        end
      end
      @(posedge clk);
      for (int u = 0; u < 2; u++) begin
        acc  = iv[u] && m_in_ready(u, ordy[u]);
        emit = m_out_valid(u) && ordy[u];
        m_edge(u, acc, emit, dat[u]);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
`ifdef PIPE_REG_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
